text_render_controller: RTL and testbench

//  Sequences the 16x32 glyph font ROM (6-bit glyph code, 512 bits/glyph) for a
//  640x480 text screen of 40x15 cells, and shares one single-port text RAM

---
 rtl/text_render_pkg.sv | 48 ++++
 rtl/text_fetch_scheduler.sv | 63 ++++++
 rtl/text_render_controller.sv | 132 +++++++++++++
 tb/tb_text_render_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_render_pkg.sv
// rtl/text_render_pkg.sv - shared constants, types and cell address helper for the text renderer
//
// Purpose : screen timing constants, text grid geometry, glyph/address types,
//           the RAM command bundle handed from the scheduler to the top, and
//           the row/column to cell-index helper (row*40 built from shifts).
// Ports   : none (package)

package text_render_pkg;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 10;

    localparam logic [COORD_W-1:0] H_ACTIVE = 10'd640;
    localparam logic [COORD_W-1:0] H_TOTAL  = 10'd800;
    localparam logic [COORD_W-1:0] V_ACTIVE = 10'd480;
    localparam logic [COORD_W-1:0] V_TOTAL  = 10'd525;

    localparam int COLS       = 40;
    localparam int ROWS       = 15;
    localparam int CELL_W     = 16;
    localparam int CELL_H     = 32;
    localparam int GLYPH_BITS = 6;

    localparam int CELL_W_BITS = $clog2(CELL_W);
    localparam int CELL_H_BITS = $clog2(CELL_H);

    localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(COLS * ROWS);

    typedef logic [GLYPH_BITS-1:0] glyph_t;
    typedef logic [ADDR_W-1:0]     cell_addr_t;

    // One cycle's worth of decisions for the shared text RAM port.
    typedef struct packed {
        logic       re;
        logic       we;
        logic       ack;
        cell_addr_t addr;
        glyph_t     wdata;
    } ram_cmd_t;

    // row*COLS + col with COLS = 40 = 32 + 8, so no multiplier is needed.
    function automatic cell_addr_t cell_index(input logic [3:0] row, input logic [5:0] col);
        cell_addr_t r;
        r = {6'd0, row};
        return (r << 5) + (r << 3) + {4'd0, col};
    endfunction

endpackage

// File: rtl/text_fetch_scheduler.sv
// rtl/text_fetch_scheduler.sv - display fetch slot detection, cell addressing and writer arbitration
//
// Purpose : decides, from the current pixel coordinate, whether this cycle is
//           a display fetch slot; if not, grants the writer. Purely combinational;
//           the top registers the resulting command onto the RAM pins.
// Ports   : x, y          in  current pixel column / line
//           wr_req        in  writer request (held until acknowledged)
//           wr_addr       in  writer cell index
//           wr_data       in  writer glyph code
//           ack_busy      in  registered wr_ack, blocks back-to-back grants
//           cmd           out RAM command for this cycle (re/we/ack/addr/wdata)

module text_fetch_scheduler
    import text_render_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [GLYPH_BITS-1:0] wr_data,
    input  logic               ack_busy,
    output ram_cmd_t           cmd
);

    localparam logic [5:0] LAST_FETCH_COL = 6'(COLS - 2);
    localparam logic [3:0] FETCH_PHASE    = 4'(CELL_W - 3);

    logic [5:0]         cell_col;
    logic [COORD_W-1:0] next_line;
    logic               mid_slot;
    logic               end_slot;
    logic               slot;
    logic [3:0]         slot_row;
    logic [5:0]         slot_col;

    assign cell_col  = x[COORD_W-1:CELL_W_BITS];
    assign next_line = (y == V_TOTAL - 10'd1) ? '0 : y + 10'd1;

    // Mid-line slots prefetch the next cell three pixels before its boundary.
    assign mid_slot = (x[CELL_W_BITS-1:0] == FETCH_PHASE) && (cell_col <= LAST_FETCH_COL)
                      && (y < V_ACTIVE);
    // Line-end slot prefetches cell 0 of whichever line comes next.
    assign end_slot = (x == H_TOTAL - 10'd3) && (next_line < V_ACTIVE);
    assign slot     = mid_slot || end_slot;

    assign slot_row = end_slot ? next_line[CELL_H_BITS+3:CELL_H_BITS] : y[CELL_H_BITS+3:CELL_H_BITS];
    assign slot_col = end_slot ? 6'd0 : cell_col + 6'd1;

    always_comb begin
        cmd = '0;
        if (slot) begin
            cmd.re   = 1'b1;
            cmd.addr = cell_index(slot_row, slot_col);
        end else if (wr_req && !ack_busy) begin
            // Out-of-range writes are acknowledged but never reach the RAM.
            cmd.ack   = 1'b1;
            cmd.we    = (wr_addr < CELLS);
            cmd.addr  = wr_addr;
            cmd.wdata = wr_data;
        end
    end

endmodule

// File: rtl/text_render_controller.sv
// rtl/text_render_controller.sv - text screen renderer: text RAM sequencing and font ROM feed
//
// Purpose : registers the scheduler's RAM command onto the text RAM pins,
//           pipelines fetched glyph codes (next_char -> cur_char) so each cell's
//           code is ready exactly at its first pixel, and registers the font
//           coordinates and pixel-valid flag with one cycle of latency.
//           Optional cursor blink overlay is built when CURSOR_EN is defined.
// Ports   : VGA_clk, reset               clock, synchronous active-high reset
//           xPixel, yPixel               current pixel coordinate
//           wr_req/wr_addr/wr_data/wr_ack writer handshake
//           ram_addr/ram_re/ram_we/ram_wdata/ram_rdata  text RAM port
//           currentLetter/font_x/font_y  font ROM lookup
//           pixel_en                     registered coordinate is in the text area
//           cursor_on/cursor_addr        cursor overlay (CURSOR_EN only)

module text_render_controller
    import text_render_pkg::*;
(
    input  logic                  VGA_clk,
    input  logic                  reset,
    input  logic [COORD_W-1:0]    xPixel,
    input  logic [COORD_W-1:0]    yPixel,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [GLYPH_BITS-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [GLYPH_BITS-1:0] ram_wdata,
    input  logic [GLYPH_BITS-1:0] ram_rdata,
    output logic [GLYPH_BITS-1:0] currentLetter,
    output logic [3:0]            font_x,
    output logic [4:0]            font_y,
    output logic                  pixel_en,
    output logic                  cursor_on,
    input  logic [ADDR_W-1:0]     cursor_addr
);

    ram_cmd_t cmd;
    logic     rd_pending;
    glyph_t   next_char;
    glyph_t   cur_char;
    logic     in_area;

    text_fetch_scheduler u_sched (
        .x        (xPixel),
        .y        (yPixel),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ack_busy (wr_ack),
        .cmd      (cmd)
    );

    assign in_area       = (xPixel < H_ACTIVE) && (yPixel < V_ACTIVE);
    assign currentLetter = cur_char;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
            wr_ack     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rd_pending <= 1'b0;
            next_char  <= '0;
            cur_char   <= '0;
            font_x     <= '0;
            font_y     <= '0;
            pixel_en   <= 1'b0;
        end else begin
            ram_re <= cmd.re;
            ram_we <= cmd.we;
            wr_ack <= cmd.ack;
            if (cmd.re || cmd.ack) begin
                ram_addr <= cmd.addr;
            end
            if (cmd.ack) begin
                ram_wdata <= cmd.wdata;
            end
            // Read data arrives the cycle after the strobe is on the pins.
            rd_pending <= ram_re;
            if (rd_pending) begin
                next_char <= ram_rdata;
            end
            // Swap in the prefetched code on the cell's first pixel; hold outside the text area.
            if (in_area && (xPixel[CELL_W_BITS-1:0] == '0)) begin
                cur_char <= next_char;
            end
            font_x   <= xPixel[CELL_W_BITS-1:0];
            font_y   <= yPixel[CELL_H_BITS-1:0];
            pixel_en <= in_area;
        end
    end

`ifdef CURSOR_EN
    localparam int BLINK_FRAMES = 30;
    localparam int FRAME_W      = $clog2(BLINK_FRAMES + 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_off;
    cell_addr_t         disp_cell;

    // frame_cnt counts frame starts within the current phase (1..BLINK_FRAMES);
    // it starts at 0 so the first frame after reset opens the first phase.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
            disp_cell <= '0;
        end else begin
            if ((xPixel == '0) && (yPixel == '0)) begin
                if (frame_cnt == FRAME_W'(BLINK_FRAMES)) begin
                    frame_cnt <= FRAME_W'(1);
                    blink_off <= ~blink_off;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
            disp_cell <= cell_index(yPixel[CELL_H_BITS+3:CELL_H_BITS], xPixel[COORD_W-1:CELL_W_BITS]);
        end
    end

    assign cursor_on = pixel_en && !blink_off && (disp_cell == cursor_addr);
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor_addr;
    assign cursor_on     = 1'b0;
`endif

endmodule

// File: tb/tb_text_render_controller.sv
// tb/tb_text_render_controller.sv - directed self-checking bench for text_render_controller

module tb_text_render_controller;

    logic       VGA_clk = 1'b0;
    logic       reset;
    logic [9:0] xPixel, yPixel;
    logic       wr_req;
    logic [9:0] wr_addr;
    logic [5:0] wr_data;
    logic       wr_ack;
    logic [9:0] ram_addr;
    logic       ram_re, ram_we;
    logic [5:0] ram_wdata;
    logic [5:0] ram_rdata;
    logic [5:0] currentLetter;
    logic [3:0] font_x;
    logic [4:0] font_y;
    logic       pixel_en;
    logic       cursor_on;
    logic [9:0] cursor_addr;

    logic       preload;
    logic [5:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    text_render_controller dut (
        .VGA_clk       (VGA_clk),
        .reset         (reset),
        .xPixel        (xPixel),
        .yPixel        (yPixel),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .ram_addr      (ram_addr),
        .ram_re        (ram_re),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .currentLetter (currentLetter),
        .font_x        (font_x),
        .font_y        (font_y),
        .pixel_en      (pixel_en),
        .cursor_on     (cursor_on),
        .cursor_addr   (cursor_addr)
    );

    always #5 VGA_clk = ~VGA_clk;

    // Synchronous single-port text RAM: read data valid the cycle after ram_re.
    always @(posedge VGA_clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (i == 0) ? 6'd1 : (i == 1) ? 6'd2 : 6'd0;
            end
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge VGA_clk);
        #1;
    endtask

    task automatic drive(input int x, input int y);
        xPixel = 10'(x);
        yPixel = 10'(y);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int wes;
        reset = 1'b1; preload = 1'b1;
        xPixel = '0; yPixel = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        cursor_addr = 10'd3;
        tick(); tick();
        check("rst_ack", wr_ack, 0);
        check("rst_re", ram_re, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_letter", currentLetter, 0);
        check("rst_pen", pixel_en, 0);
        check("rst_cursor", cursor_on, 0);
        preload = 1'b0;
        reset = 1'b0;

        // Line-start prefetch from the last line of the frame wraps to row 0.
        drive(797, 524);
        check("wrap_re", ram_re, 1);
        check("wrap_addr", ram_addr, 0);
        drive(798, 524);
        drive(799, 524);
        for (int x = 0; x < 32; x++) begin
            drive(x, 0);
            check($sformatf("letter_x%0d", x), currentLetter, (x < 16) ? 1 : 2);
            check($sformatf("fontx_x%0d", x), font_x, x % 16);
            if (x == 13) begin
                check("slot13_re", ram_re, 1);
                check("slot13_addr", ram_addr, 1);
            end
        end
        check("pen_line0", pixel_en, 1);

        // Writer arriving on a slot waits one cycle.
        wr_req = 1'b1; wr_addr = 10'd41; wr_data = 6'd5;
        drive(29, 0);
        check("w41_slot_re", ram_re, 1);
        check("w41_slot_we", ram_we, 0);
        check("w41_slot_ack", wr_ack, 0);
        check("w41_slot_addr", ram_addr, 2);
        drive(30, 0);
        check("w41_we", ram_we, 1);
        check("w41_ack", wr_ack, 1);
        check("w41_re", ram_re, 0);
        check("w41_addr", ram_addr, 41);
        check("w41_wdata", ram_wdata, 5);
        wr_req = 1'b0;
        drive(31, 0);
        check("w41_we_off", ram_we, 0);
        check("w41_ack_off", wr_ack, 0);
        check("w41_mem", mem[41], 5);

        // Out-of-range address: acknowledged once, never written.
        wr_req = 1'b1; wr_addr = 10'd600; wr_data = 6'd7;
        acks = 0; wes = 0;
        for (int i = 0; i < 6; i++) begin
            drive(100, 0);
            if (wr_ack) begin acks++; wr_req = 1'b0; end
            if (ram_we) wes++;
        end
        check("w600_acks", acks, 1);
        check("w600_wes", wes, 0);

        // Last valid cell is writable.
        wr_req = 1'b1; wr_addr = 10'd599; wr_data = 6'd3;
        drive(100, 0);
        check("w599_we", ram_we, 1);
        wr_req = 1'b0;
        drive(101, 0);
        check("w599_mem", mem[599], 3);

        // Slot boundaries.
        drive(797, 479);
        check("no_read_479", ram_re, 0);
        drive(797, 478);
        check("read_478_re", ram_re, 1);
        check("read_478_addr", ram_addr, 560);
        drive(621, 448);
        check("last_cell_re", ram_re, 1);
        check("last_cell_addr", ram_addr, 599);
        drive(13, 480);
        check("vblank_no_re", ram_re, 0);
        drive(637, 0);
        check("col40_no_re", ram_re, 0);

        // Text area edges and font_y.
        drive(639, 479);
        check("pen_corner", pixel_en, 1);
        drive(640, 0);
        check("pen_x640", pixel_en, 0);
        drive(0, 480);
        check("pen_y480", pixel_en, 0);
        drive(5, 37);
        check("fonty_37", font_y, 5);
        check("fontx_5", font_x, 5);

        // Reset in the middle of a write request.
        drive(797, 524); drive(798, 524); drive(799, 524); drive(0, 0);
        check("pre_rst_letter", currentLetter, 1);
        wr_req = 1'b1; wr_addr = 10'd7; wr_data = 6'd9;
        reset = 1'b1;
        drive(100, 0);
        check("midrst_ack", wr_ack, 0);
        check("midrst_we", ram_we, 0);
        check("midrst_re", ram_re, 0);
        check("midrst_pen", pixel_en, 0);
        check("midrst_letter", currentLetter, 0);
        check("midrst_fontx", font_x, 0);
        reset = 1'b0;
        drive(100, 0);
        check("postrst_ack", wr_ack, 1);
        check("postrst_we", ram_we, 1);
        check("postrst_addr", ram_addr, 7);
        wr_req = 1'b0;
        drive(101, 0);

`ifdef CURSOR_EN
        for (int f = 0; f <= 60; f++) begin
            drive(0, 0);
            drive(48, 0);
            if (f == 0 || f == 29 || f == 30 || f == 59 || f == 60) begin
                check($sformatf("cursor_f%0d", f), cursor_on, (f < 30 || f >= 60) ? 1 : 0);
            end
            if (f == 0) begin
                drive(47, 0);
                check("cursor_x47", cursor_on, 0);
                drive(63, 0);
                check("cursor_x63", cursor_on, 1);
                drive(64, 0);
                check("cursor_x64", cursor_on, 0);
            end
        end
`else
        drive(48, 0);
        check("cursor_tied", cursor_on, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
